pg_seq_adder: RTL and testbench

//  Multi-cycle wide adder front end. Accepts two BITS*SLICES-bit operands, then walks them one

---
 rtl/pg_seq_adder_if.sv | 44 ++++
 rtl/pg_seq_adder.sv | 131 +++++++++++++
 tb/tb_pg_seq_adder.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pg_seq_adder_if.sv
// Bundle between pg_seq_adder and its neighbours: operand/result handshakes plus the CLL slice link.
// PG_SEQ_SUB_EN adds the `sub` operand-side control bit.
interface pg_seq_adder_if #(
    parameter int BITS   = 8,
    parameter int SLICES = 4
);
    localparam int W = BITS * SLICES;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic            Cin;
`ifdef PG_SEQ_SUB_EN
    logic            sub;
`endif
    logic [BITS-1:0] P_out;
    logic [BITS-1:0] G_out;
    logic            Cin_out;
    logic [BITS-1:0] Cout_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    Sum;
    logic            Cout;
    logic            Ovf;

    modport slave (
        input  in_valid, A, B, Cin,
`ifdef PG_SEQ_SUB_EN
        input  sub,
`endif
        input  Cout_in, out_ready,
        output in_ready, P_out, G_out, Cin_out, out_valid, Sum, Cout, Ovf
    );

    modport master (
        output in_valid, A, B, Cin,
`ifdef PG_SEQ_SUB_EN
        output sub,
`endif
        output Cout_in, out_ready,
        input  in_ready, P_out, G_out, Cin_out, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/pg_seq_adder.sv
// Multi-cycle wide adder: walks BITS-wide slices LSB first through an external CLL, one per cycle.
// Optional subtract mode is enabled by defining PG_SEQ_SUB_EN.
module pg_seq_adder #(
    parameter int BITS   = 8,
    parameter int SLICES = 4
) (
    input  logic           clk,
    input  logic           rst,
    pg_seq_adder_if.slave  bus
);
    localparam int W  = BITS * SLICES;
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state;
    state_e          nxt;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    sumreg;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            coutreg;
    logic            ovfreg;
    logic [BITS-1:0] sla;
    logic [BITS-1:0] slb;
    logic [BITS-1:0] sumslice;
    logic [W-1:0]    bsel;
    logic            cinsel;

    // Subtraction is A + ~B + 1, so it only changes what gets captured on accept.
`ifdef PG_SEQ_SUB_EN
    assign bsel   = bus.sub ? ~bus.B : bus.B;
    assign cinsel = bus.sub | bus.Cin;
`else
    assign bsel   = bus.B;
    assign cinsel = bus.Cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) nxt = RUN;
            RUN:     if (idx == LAST) nxt = DONE;
            DONE:    if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.P_out     = '0;
        bus.G_out     = '0;
        bus.Cin_out   = 1'b0;
        case (state)
            IDLE: bus.in_ready = !rst;
            RUN: begin
                bus.P_out   = sla ^ slb;
                bus.G_out   = sla & slb;
                bus.Cin_out = carry;
            end
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sla = '0;
        slb = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (idx == IW'(s)) begin
                sla = opa[s*BITS +: BITS];
                slb = opb[s*BITS +: BITS];
            end
        end
    end

    // Per-bit carries come back from the CLL; bit 0 uses the registered slice carry.
    assign sumslice = (sla ^ slb) ^ {bus.Cout_in[BITS-2:0], carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            opa     <= '0;
            opb     <= '0;
            sumreg  <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            coutreg <= 1'b0;
            ovfreg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.A;
                        opb   <= bsel;
                        carry <= cinsel;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int s = 0; s < SLICES; s++) begin
                        if (idx == IW'(s)) begin
                            sumreg[s*BITS +: BITS] <= sumslice;
                        end
                    end
                    carry <= bus.Cout_in[BITS-1];
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        coutreg <= bus.Cout_in[BITS-1];
                        ovfreg  <= bus.Cout_in[BITS-1] ^ bus.Cout_in[BITS-2];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Sum  = sumreg;
    assign bus.Cout = coutreg;
    assign bus.Ovf  = ovfreg;
endmodule

// File: tb/tb_pg_seq_adder.sv
// Testbench for pg_seq_adder with a behavioural CLL on the slice link and an arithmetic reference model.
// Define PG_SEQ_SUB_EN to also exercise subtract mode.
module tb_pg_seq_adder;
    localparam int BITS   = 8;
    localparam int SLICES = 4;
    localparam int W      = BITS * SLICES;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pg_seq_adder_if #(.BITS(BITS), .SLICES(SLICES)) bus ();

    pg_seq_adder #(.BITS(BITS), .SLICES(SLICES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry-lookahead stand-in: per-bit carry outs of the slice the DUT presents.
    always_comb begin
        logic c;
        logic [BITS-1:0] co;
        co = '0;
        c  = bus.Cin_out;
        for (int i = 0; i < BITS; i++) begin
            co[i] = bus.G_out[i] | (bus.P_out[i] & c);
            c     = co[i];
        end
        bus.Cout_in = co;
    end

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sb,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        if (sb) begin
            t  = {1'b0, a} - {1'b0, b};
            s  = t[W-1:0];
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s  = t[W-1:0];
            co = t[W];
            ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
    endfunction

    // Drives one operation from a negedge and returns the first result seen; ends on a negedge in IDLE.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input int holdCycles,
                                 output logic [W-1:0] s, output logic co, output logic ov,
                                 output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        lat = 0;
        s   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            tmo = 1'b1;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            tmo = 1'b1;
            return;
        end
        s  = bus.Sum;
        co = bus.Cout;
        ov = bus.Ovf;
        repeat (holdCycles) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.Sum !== '0) begin failures++; $display("[TB] FAIL reset_sum got=%h exp=0", bus.Sum); end
        checks++; if (bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b%b exp=00", bus.Cout, bus.Ovf); end
        checks++; if (bus.P_out !== '0 || bus.G_out !== '0 || bus.Cin_out !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_pg got=%h/%h/%b exp=0/0/0", bus.P_out, bus.G_out, bus.Cin_out);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_directed;
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        bit tmo;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, s, co, ov, lat, tmo);
        checks++; if (tmo !== 1'b0) begin failures++; $display("[TB] FAIL wrap_timeout got=%b exp=0", tmo); end
        checks++; if ({s, co, ov} !== {32'h0000_0000, 1'b1, 1'b0}) begin
            failures++; $display("[TB] FAIL wrap_result got=%h/%b/%b exp=00000000/1/0", s, co, ov);
        end
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, s, co, ov, lat, tmo);
        checks++; if ({s, co, ov} !== {32'h8000_0000, 1'b0, 1'b1} || tmo) begin
            failures++; $display("[TB] FAIL ovf_result got=%h/%b/%b exp=80000000/0/1", s, co, ov);
        end
    endtask

    task automatic test_latency;
        logic [W-1:0] a, b, es;
        logic ec, eo;
        int lat;
        bit sawReady;
        a = 32'h0F0F_1234;
        b = 32'h00FF_00FF;
        model(a, b, 1'b1, 1'b0, es, ec, eo);
        bus.A = a;
        bus.B = b;
        bus.Cin = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        // Keep in_valid high with junk operands while busy: it must be ignored.
        bus.A = $urandom;
        bus.B = $urandom;
        bus.Cin = 1'b0;
        checks++; if (bus.P_out !== (a[7:0] ^ b[7:0]) || bus.G_out !== (a[7:0] & b[7:0]) || bus.Cin_out !== 1'b1) begin
            failures++; $display("[TB] FAIL slice0_pg got=%h/%h/%b exp=%h/%h/1", bus.P_out, bus.G_out, bus.Cin_out,
                                 a[7:0] ^ b[7:0], a[7:0] & b[7:0]);
        end
        lat = 0;
        sawReady = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) sawReady = 1'b1;
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != SLICES) begin failures++; $display("[TB] FAIL latency got=%0d exp=%0d", lat, SLICES); end
        checks++; if (sawReady || bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL busy_in_ready got=1 exp=0"); end
        checks++; if ({bus.Sum, bus.Cout, bus.Ovf} !== {es, ec, eo}) begin
            failures++; $display("[TB] FAIL latency_result got=%h/%b/%b exp=%h/%b/%b", bus.Sum, bus.Cout, bus.Ovf, es, ec, eo);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL idle_after_done got=%b/%b exp=1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_hold;
        int n;
        bus.A = 32'h8000_0000;
        bus.B = 32'h8000_0000;
        bus.Cin = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.out_valid, bus.in_ready, bus.Sum, bus.Cout, bus.Ovf} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b1}) begin
                failures++; $display("[TB] FAIL hold_%0d got=%b/%b/%h/%b/%b exp=1/0/00000000/1/1", i,
                                     bus.out_valid, bus.in_ready, bus.Sum, bus.Cout, bus.Ovf);
            end
            if (i < 3) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        bit tmo;
        bus.A = 32'hDEAD_BEEF;
        bus.B = 32'h0123_4567;
        bus.Cin = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.Sum, bus.in_ready} !== {1'b0, 32'h0, 1'b0}) begin
            failures++; $display("[TB] FAIL midrun_reset got=%b/%h/%b exp=0/00000000/0", bus.out_valid, bus.Sum, bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrun_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 0, s, co, ov, lat, tmo);
        checks++; if ({s, co, ov} !== {32'h2345_6789, 1'b0, 1'b0} || tmo) begin
            failures++; $display("[TB] FAIL after_reset_sum got=%h/%b/%b exp=23456789/0/0", s, co, ov);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, s, es;
        logic cin, co, ov, ec, eo;
        int lat;
        bit tmo;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom_range(0, 1));
            case (i % 4)
                1: b = ~a;
                2: b = 32'hFFFF_FFFF;
                3: begin a = a | 32'h8000_0000; b = b | 32'h8000_0000; end
                default: ;
            endcase
            model(a, b, cin, 1'b0, es, ec, eo);
            applyStimulus(a, b, cin, $urandom_range(0, 3), s, co, ov, lat, tmo);
            checks++; if ({s, co, ov} !== {es, ec, eo} || tmo) begin
                failures++; $display("[TB] FAIL rand_%0d got=%h/%b/%b exp=%h/%b/%b (a=%h b=%h cin=%b)", i, s, co, ov, es, ec, eo, a, b, cin);
            end
            checks++; if (lat != SLICES) begin failures++; $display("[TB] FAIL rand_lat_%0d got=%0d exp=%0d", i, lat, SLICES); end
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        logic [W-1:0] expq[$];
        logic [W-1:0] es, got;
        logic ec, eo;
        bit refresh;
        int results;
        results = 0;
        refresh = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.Cin = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.out_valid && expq.size() > 0) begin
                got = expq.pop_front();
                results++;
                checks++; if (bus.Sum !== got) begin failures++; $display("[TB] FAIL b2b_sum got=%h exp=%h", bus.Sum, got); end
            end
            if (acc.size() >= 3) bus.in_valid = 1'b0;
            if (refresh) begin
                bus.A = $urandom;
                bus.B = $urandom;
                refresh = 1'b0;
            end
            if (bus.in_ready && bus.in_valid) begin
                model(bus.A, bus.B, 1'b0, 1'b0, es, ec, eo);
                expq.push_back(es);
                acc.push_back(cyc);
                refresh = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (acc.size() != 3 || results != 3) begin
            failures++; $display("[TB] FAIL b2b_count got=%0d/%0d exp=3/3", acc.size(), results);
        end else begin
            checks++; if (acc[1] - acc[0] != SLICES + 2 || acc[2] - acc[1] != SLICES + 2) begin
                failures++; $display("[TB] FAIL b2b_spacing got=%0d/%0d exp=%0d", acc[1] - acc[0], acc[2] - acc[1], SLICES + 2);
            end
        end
    endtask

`ifdef PG_SEQ_SUB_EN
    task automatic test_sub;
        logic [W-1:0] a, b, s, es;
        logic co, ov, ec, eo;
        int lat;
        bit tmo;
        bus.sub = 1'b1;
        applyStimulus(32'd5, 32'd7, 1'b0, 0, s, co, ov, lat, tmo);
        checks++; if ({s, co} !== {32'hFFFF_FFFE, 1'b0} || tmo) begin
            failures++; $display("[TB] FAIL sub_5_7 got=%h/%b exp=fffffffe/0", s, co);
        end
        applyStimulus(32'd7, 32'd5, 1'b0, 0, s, co, ov, lat, tmo);
        checks++; if ({s, co} !== {32'd2, 1'b1} || tmo) begin
            failures++; $display("[TB] FAIL sub_7_5 got=%h/%b exp=00000002/1", s, co);
        end
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 0) ? a : $urandom;
            model(a, b, 1'b0, 1'b1, es, ec, eo);
            applyStimulus(a, b, 1'($urandom_range(0, 1)), 0, s, co, ov, lat, tmo);
            checks++; if ({s, co, ov} !== {es, ec, eo} || tmo) begin
                failures++; $display("[TB] FAIL sub_rand_%0d got=%h/%b/%b exp=%h/%b/%b", i, s, co, ov, es, ec, eo);
            end
        end
        bus.sub = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
`ifdef PG_SEQ_SUB_EN
        bus.sub = 1'b0;
`endif
        @(negedge clk);
        test_reset;
        test_directed;
        test_latency;
        test_hold;
        test_reset_mid_run;
        test_random;
        test_back_to_back;
`ifdef PG_SEQ_SUB_EN
        test_sub;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
